exe_mem_stage: RTL and testbench

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

---
 rtl/exe_mem_stage.sv | 159 +++++++++++++++
 tb/tb_exe_mem_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage.sv
// Execute-to-memory pipeline register with a one-deep skid buffer.
// It finalises the writeback result and issues a one-cycle fetch redirect for taken control flow.
module exe_mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            compare_out_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            op_word_i,
    input  logic            op_branch_i,
    input  logic            op_jal_i,
    input  logic            op_jalr_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            rd_wen_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_idx_o,
    output logic            rd_wen_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            flush_i
);

    localparam int EW = XLEN + 6;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic            ex_ready_q;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            accept_s;
    logic            drain_s;
    logic            taken_s;
    logic            new_wen_s;
    logic [XLEN-1:0] new_res_s;
    logic [XLEN-1:0] target_s;
    logic [EW-1:0]   new_entry_s;

    assign accept_s    = ex_valid_i & ex_ready_q;
    assign drain_s     = (state_q != S_EMPTY) & mem_ready_i;
    assign new_wen_s   = rd_wen_i & ~op_branch_i & (rd_idx_i != 5'd0);
    assign new_entry_s = {new_res_s, rd_idx_i, new_wen_s};

    // Decode the offered instruction into its writeback value and redirect target
    always_comb begin
        new_res_s = alu_out_i;
        taken_s   = 1'b0;
        if (op_jal_i || op_jalr_i) begin
            new_res_s = pc_i + XLEN'(3'd4);
            taken_s   = 1'b1;
        end else if (op_word_i) begin
            new_res_s = {{(XLEN-32){alu_out_i[31]}}, alu_out_i[31:0]};
        end else if (op_branch_i) begin
            taken_s   = compare_out_i;
        end else begin
            new_res_s = alu_out_i;
        end
        if (op_jalr_i) begin
            target_s = {alu_out_i[XLEN-1:1], 1'b0};
        end else begin
            target_s = pc_i + imm_i;
        end
    end

    // Occupancy FSM, entry movement and redirect generation; flush overrides everything
    always_comb begin
        state_d       = state_q;
        main_d        = main_q;
        skid_d        = skid_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        main_d  = new_entry_s;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (accept_s && !drain_s) begin
                        skid_d  = new_entry_s;
                        state_d = S_TWO;
                    end else if (!accept_s && drain_s) begin
                        state_d = S_EMPTY;
                    end else if (accept_s && drain_s) begin
                        main_d  = new_entry_s;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_TWO: begin
                    if (drain_s) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_TWO;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
            if (accept_s && taken_s) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = target_s;
            end else begin
                redir_valid_d = 1'b0;
            end
        end
    end

    // State and payload registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            main_q        <= {EW{1'b0}};
            skid_q        <= {EW{1'b0}};
            ex_ready_q    <= 1'b1;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= {XLEN{1'b0}};
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            ex_ready_q    <= (state_d != S_TWO);
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign ex_ready_o       = ex_ready_q;
    assign mem_valid_o      = (state_q != S_EMPTY);
    assign result_o         = main_q[EW-1:6];
    assign rd_idx_o         = main_q[5:1];
    assign rd_wen_o         = main_q[0];
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: expected entries are queued at acceptance
// and compared when the stage hands them to MEM.
module tb_exe_mem_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic [XLEN-1:0] alu_out_i;
    logic            compare_out_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            op_word_i, op_branch_i, op_jal_i, op_jalr_i;
    logic [4:0]      rd_idx_i;
    logic            rd_wen_i;
    logic            mem_valid_o;
    logic            mem_ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_idx_o;
    logic            rd_wen_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_i;

    exe_mem_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_out_i(alu_out_i), .compare_out_i(compare_out_i),
        .pc_i(pc_i), .imm_i(imm_i),
        .op_word_i(op_word_i), .op_branch_i(op_branch_i),
        .op_jal_i(op_jal_i), .op_jalr_i(op_jalr_i),
        .rd_idx_i(rd_idx_i), .rd_wen_i(rd_wen_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .result_o(result_o), .rd_idx_o(rd_idx_o), .rd_wen_o(rd_wen_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] exp_rpc;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic v, input int cls, input logic [63:0] alu, input logic cmp,
                         input logic [63:0] pc, input logic [63:0] imm, input logic [4:0] rd,
                         input logic wen);
        ex_valid_i    = v;
        alu_out_i     = alu;
        compare_out_i = cmp;
        pc_i          = pc;
        imm_i         = imm;
        op_word_i     = (cls == 1);
        op_branch_i   = (cls == 2);
        op_jal_i      = (cls == 3);
        op_jalr_i     = (cls == 4);
        rd_idx_i      = rd;
        rd_wen_i      = wen;
    endtask

    // One clock: check handshake outputs, update the model, advance, check the redirect.
    task automatic cycle();
        logic        acc, taken, exp_rv;
        logic [63:0] tgt, mres;
        ent_t        e, m;
        check_eq("ex_ready", {63'd0, ex_ready_o}, {63'd0, exp_q.size() < 2});
        check_eq("mem_valid", {63'd0, mem_valid_o}, {63'd0, exp_q.size() > 0});
        acc = ex_valid_i && (exp_q.size() < 2);
        if (exp_q.size() > 0 && mem_ready_i) begin
            m = exp_q.pop_front();
            check_eq("result", result_o, m.res);
            check_eq("rd_idx", {59'd0, rd_idx_o}, {59'd0, m.rd});
            check_eq("rd_wen", {63'd0, rd_wen_o}, {63'd0, m.wen});
        end
        exp_rv = 1'b0;
        if (flush_i) begin
            exp_q.delete();
        end else if (acc) begin
            if (op_jal_i || op_jalr_i) mres = pc_i + 64'd4;
            else if (op_word_i)        mres = {{32{alu_out_i[31]}}, alu_out_i[31:0]};
            else                       mres = alu_out_i;
            e.res = mres;
            e.rd  = rd_idx_i;
            e.wen = rd_wen_i && !op_branch_i && (rd_idx_i != 5'd0);
            exp_q.push_back(e);
            taken = (op_branch_i && compare_out_i) || op_jal_i || op_jalr_i;
            tgt   = op_jalr_i ? (alu_out_i & ~64'd1) : (pc_i + imm_i);
            if (taken) begin
                exp_rv  = 1'b1;
                exp_rpc = tgt;
            end
        end
        @(posedge clk);
        #1;
        check_eq("redir_valid", {63'd0, redirect_valid_o}, {63'd0, exp_rv});
        check_eq("redir_pc", redirect_pc_o, exp_rpc);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_mem_valid", {63'd0, mem_valid_o}, 64'd0);
        check_eq("rst_ex_ready", {63'd0, ex_ready_o}, 64'd1);
        check_eq("rst_redir_valid", {63'd0, redirect_valid_o}, 64'd0);
        check_eq("rst_redir_pc", redirect_pc_o, 64'd0);
        check_eq("rst_result", result_o, 64'd0);
        check_eq("rst_rd_idx", {59'd0, rd_idx_o}, 64'd0);
        check_eq("rst_rd_wen", {63'd0, rd_wen_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        mem_ready_i = 1'b1;
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        exp_rpc = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        // addw-style sign extension
        offer(1'b1, 1, 64'h0000_0000_8000_0001, 1'b0, 64'h100, 64'd0, 5'd3, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("addw_valid", {63'd0, mem_valid_o}, 64'd1);
        check_eq("addw_result", result_o, 64'hFFFF_FFFF_8000_0001);
        cycle();

        // taken branch, then not-taken branch
        offer(1'b1, 2, 64'd0, 1'b1, 64'h8000_0010, -64'sd16, 5'd5, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("br_pulse", {63'd0, redirect_valid_o}, 64'd1);
        check_eq("br_target", redirect_pc_o, 64'h8000_0000);
        check_eq("br_wen", {63'd0, rd_wen_o}, 64'd0);
        cycle();
        offer(1'b1, 2, 64'd0, 1'b0, 64'h8000_0040, 64'd32, 5'd5, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("br_nt_pulse", {63'd0, redirect_valid_o}, 64'd0);
        cycle();

        // jalr
        offer(1'b1, 4, 64'h8000_0123, 1'b0, 64'h8000_0100, 64'd0, 5'd1, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("jalr_target", redirect_pc_o, 64'h8000_0122);
        check_eq("jalr_result", result_o, 64'h8000_0104);
        check_eq("jalr_wen", {63'd0, rd_wen_o}, 64'd1);
        cycle();

        // x0 destination
        offer(1'b1, 0, 64'h1234, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("x0_wen", {63'd0, rd_wen_o}, 64'd0);
        cycle();

        // backpressure: A then B held, then drained in order
        mem_ready_i = 1'b0;
        offer(1'b1, 0, 64'hAAAA, 1'b0, 64'd0, 64'd0, 5'd2, 1'b1);
        cycle();
        offer(1'b1, 0, 64'hBBBB, 1'b0, 64'd0, 64'd0, 5'd4, 1'b1);
        cycle();
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("bp_ready_low", {63'd0, ex_ready_o}, 64'd0);
        check_eq("bp_hold_a", result_o, 64'hAAAA);
        cycle();
        check_eq("bp_still_a", result_o, 64'hAAAA);
        mem_ready_i = 1'b1;
        cycle();
        check_eq("bp_then_b", result_o, 64'hBBBB);
        cycle();
        check_eq("bp_ready_back", {63'd0, ex_ready_o}, 64'd1);

        // flush in TWO with a taken jal offered
        mem_ready_i = 1'b0;
        offer(1'b1, 0, 64'h1111, 1'b0, 64'd0, 64'd0, 5'd6, 1'b1);
        cycle();
        offer(1'b1, 0, 64'h2222, 1'b0, 64'd0, 64'd0, 5'd7, 1'b1);
        cycle();
        offer(1'b1, 3, 64'd0, 1'b0, 64'h4000, 64'h40, 5'd8, 1'b1);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        check_eq("fl_valid", {63'd0, mem_valid_o}, 64'd0);
        check_eq("fl_ready", {63'd0, ex_ready_o}, 64'd1);
        check_eq("fl_redir", {63'd0, redirect_valid_o}, 64'd0);
        mem_ready_i = 1'b1;
        repeat (3) cycle();

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            offer($urandom_range(0, 1) == 1, int'($urandom_range(0, 4)),
                  {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
            mem_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush_i = 1'b0;

        // reset while holding two entries and mid-handshake
        mem_ready_i = 1'b0;
        offer(1'b1, 3, 64'd0, 1'b0, 64'h9000, 64'h10, 5'd9, 1'b1);
        cycle();
        offer(1'b1, 0, 64'h3333, 1'b0, 64'd0, 64'd0, 5'd10, 1'b1);
        cycle();
        offer(1'b1, 3, 64'd0, 1'b0, 64'hA000, 64'h20, 5'd11, 1'b1);
        mem_ready_i = 1'b1;
        flush_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        flush_i = 1'b0;
        exp_q.delete();
        exp_rpc = 64'd0;
        offer(1'b0, 0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
